// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver.
//   SEG_BLANK  - all segments off (active-low bus)
//   SEG_TABLE  - hex nibble to {dp,g,f,e,d,c,b,a} active-low pattern, dp off
//   hex2seg()  - table lookup with the decimal point merged into bit 7
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry 15 is listed first, so SEG_TABLE[n] is the pattern for nibble n.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex2seg(input logic [3:0] nibble, input logic dp);
    logic [7:0] s;
    s    = SEG_TABLE[nibble];
    s[7] = s[7] & ~dp;
    return s;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: combinational nibble + dp + blank to active-low segment pattern.
// Ports:
//   nibble_i  in  4  hex value to show
//   dp_i      in  1  decimal point lit
//   blank_i   in  1  force all segments (dp included) off
//   seg_c_o   out 8  {dp,g,f,e,d,c,b,a}, active-low, combinational
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_c_o
);

  always_comb begin
    seg_c_o = SEG_BLANK;
    if (!blank_i) seg_c_o = hex2seg(nibble_i, dp_i);
  end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed multi-digit seven-segment scan driver.
// A free-running prescaler defines digit slots; data/dp are snapshotted once
// per frame, segments are dimmed by a duty window and registered.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   data        in  4*DIGITS  nibble i at data[4i+3:4i]
//   dp          in  DIGITS    decimal point per digit, 1 = lit
//   bright      in  4         duty level, 15 = full
//   lzb         in  1         leading-zero blanking request
//   which       out SEL_W     selected digit
//   count       out DIV_W     prescaler value
//   digit       out 4         shadow nibble at which (combinational from registers)
//   seg         out 8         registered active-low segment bus
//   frame       out 1         one-clock pulse when which wraps to 0
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DIV_W  = 15,
  parameter int unsigned SEL_W  = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [3:0]            bright,
  input  logic                  lzb,
  output logic [SEL_W-1:0]      which,
  output logic [DIV_W-1:0]      count,
  output logic [3:0]            digit,
  output logic [7:0]            seg,
  output logic                  frame
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DIGITS - 1);

  logic [DIV_W-1:0]    count_q, count_d;
  logic [SEL_W-1:0]    which_q, which_d;
  logic [4*DIGITS-1:0] data_q,  data_d;
  logic [DIGITS-1:0]   dp_q,    dp_d;
  logic [7:0]          seg_q,   seg_d;
  logic                frame_q, frame_d;

  logic tick, wrap, lit, lzb_blank;

  // Prescaler, digit select and per-frame snapshot of data/dp.
  always_comb begin
    tick    = &count_q;
    wrap    = tick && (which_q == LAST_SEL);
    count_d = count_q + DIV_W'(1);
    which_d = which_q;
    data_d  = data_q;
    dp_d    = dp_q;
    frame_d = wrap;
    if (tick) which_d = wrap ? '0 : which_q + SEL_W'(1);
    if (wrap) begin
      data_d = data;
      dp_d   = dp;
    end
  end

  assign digit = data_q[{which_q, 2'b00} +: 4];

  // Duty window: top nibble of the prescaler against the brightness level.
  assign lit = (count_q[DIV_W-1 -: 4] <= bright);

`ifdef SEG_SCAN_LZB_EN
  // Highest nonzero shadow nibble; digit 0 is never above it.
  logic [SEL_W-1:0] msnz;
  always_comb begin
    msnz = '0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (data_q[4*i +: 4] != 4'h0) msnz = SEL_W'(i);
    end
  end
  assign lzb_blank = lzb && (which_q > msnz);
`else
  logic unused_lzb;
  assign unused_lzb = lzb;
  assign lzb_blank  = 1'b0;
`endif

  seg_decoder u_dec (
    .nibble_i (digit),
    .dp_i     (dp_q[which_q]),
    .blank_i  (lzb_blank || !lit),
    .seg_c_o  (seg_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      which_q <= '0;
      data_q  <= '0;
      dp_q    <= '0;
      seg_q   <= SEG_BLANK;
      frame_q <= 1'b0;
    end else begin
      count_q <= count_d;
      which_q <= which_d;
      data_q  <= data_d;
      dp_q    <= dp_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign which = which_q;
  assign count = count_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed scoreboard bench for seg_scan_display
// (DIGITS=8, DIV_W=4: 16-clock slots, 128-clock frames).
// Expected per-digit segment values are queued when data is driven and
// popped as each slot's first lit sample appears. Leading-zero expectations
// follow SEG_SCAN_LZB_EN.
module tb_seg_scan_display;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned DIV_W  = 4;
  localparam int unsigned SEL_W  = 3;

`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB_BUILD = 1'b1;
`else
  localparam bit LZB_BUILD = 1'b0;
`endif

  localparam logic [7:0] HEX_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic                clk = 1'b0;
  logic                rst_n;
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [3:0]          bright;
  logic                lzb;
  logic [SEL_W-1:0]    which;
  logic [DIV_W-1:0]    count;
  logic [3:0]          digit;
  logic [7:0]          seg;
  logic                frame;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  seg_scan_display #(.DIGITS(DIGITS), .DIV_W(DIV_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .dp     (dp),
    .bright (bright),
    .lzb    (lzb),
    .which  (which),
    .count  (count),
    .digit  (digit),
    .seg    (seg),
    .frame  (frame)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance on negedges until which/count match, with a cycle budget.
  task automatic wait_at(input int w, input int c, input string tag);
    int n = 0;
    while (!(int'(which) == w && int'(count) == c) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 400) else begin
      errors++;
      $error("FAIL %s timeout waiting which=%0d count=%0d cycles=%0d", tag, w, c, n);
    end
  endtask

  // Queue the eight expected lit patterns for a frame showing d/p/z.
  task automatic push_frame(input logic [31:0] d, input logic [7:0] p, input logic z);
    int top = 0;
    for (int i = 7; i >= 1; i--) begin
      if (d[4*i +: 4] != 4'h0 && top == 0) top = i;
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = HEX_TAB[d[4*i +: 4]];
      if (p[i]) e[7] = 1'b0;
      if (LZB_BUILD && z && i > top) e = 8'hFF;
      exp_q.push_back(e);
    end
  endtask

  // Check one frame slot by slot; optionally drive new inputs before slot chg_at.
  task automatic scan_frame(input string tag, input int chg_at, input logic [31:0] nd,
                            input logic [7:0] np, input logic nz);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      if (i == chg_at) begin
        data = nd;
        dp   = np;
        lzb  = nz;
      end
      wait_at(i, 1, tag);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk($sformatf("%s_d%0d", tag, i), 32'(seg), 32'(e));
    end
  endtask

  initial begin
    int n;
    int lit;
    logic [7:0] first;

    rst_n  = 1'b0;
    data   = 32'hFEDC_BA98;
    dp     = 8'h00;
    bright = 4'd15;
    lzb    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg",   32'(seg),   32'h0000_00FF);
    chk("rst_which", 32'(which), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_digit", 32'(digit), 32'd0);

    // First frame after reset shows the zeroed shadow.
    rst_n = 1'b1;
    push_frame(32'h0, 8'h00, 1'b0);
    scan_frame("f1", -1, data, dp, lzb);

    n = 0;
    while (frame !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL frame_timeout cycles=%0d", n);
    end
    chk("frame_which", 32'(which), 32'd0);
    chk("frame_count", 32'(count), 32'd0);
    chk("frame_digit", 32'(digit), 32'h8);
    @(negedge clk);
    chk("frame_pulse_width", 32'(frame), 32'd0);

    // Mid-frame changes only appear on the following frame.
    push_frame(32'hFEDC_BA98, 8'h00, 1'b0);
    scan_frame("f2", 4, 32'h7654_3210, 8'h00, 1'b0);
    push_frame(32'h7654_3210, 8'h00, 1'b0);
    scan_frame("f3", 4, 32'h7654_3218, 8'h01, 1'b0);
    push_frame(32'h7654_3218, 8'h01, 1'b0);
    scan_frame("f4", 4, 32'h0000_0120, 8'h00, 1'b1);
    push_frame(32'h0000_0120, 8'h00, 1'b1);
    scan_frame("f5", 4, 32'h0, 8'h00, 1'b1);
    push_frame(32'h0, 8'h00, 1'b1);
    scan_frame("f6", -1, 32'h0, 8'h00, 1'b1);

    // Brightness 0: one lit clock per slot; brightness 7: eight.
    lzb    = 1'b0;
    bright = 4'd0;
    wait_at(0, 1, "dim0");
    first = seg;
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      if (seg !== 8'hFF) lit++;
      @(negedge clk);
    end
    chk("dim0_first", 32'(first), 32'h0000_00C0);
    chk("dim0_lit",   32'(lit),   32'd1);

    bright = 4'd7;
    wait_at(2, 1, "dim7");
    first = seg;
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      if (seg !== 8'hFF) lit++;
      @(negedge clk);
    end
    chk("dim7_first", 32'(first), 32'h0000_00C0);
    chk("dim7_lit",   32'(lit),   32'd8);

    // Asynchronous reset in the middle of a slot.
    wait_at(5, 5, "mid_rst");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seg",   32'(seg),   32'h0000_00FF);
    chk("mid_rst_which", 32'(which), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_count", 32'(count), 32'd1);
    chk("restart_which", 32'(which), 32'd0);
    chk("restart_seg",   32'(seg),   32'h0000_00C0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
